// File: rtl/mxm_operand_feeder.sv
// Operand feeder for the MxM_ReLu core: holds A (MxN) and X^T (PxN) and
// streams one A/X pair per clock in n-innermost, then m, then p order.
module mxm_operand_feeder #(
    parameter int unsigned W  = 8,
    parameter int unsigned M  = 10,
    parameter int unsigned N  = 8,
    parameter int unsigned P  = 6,
    parameter int unsigned AW = $clog2((M * N > N * P) ? M * N : N * P)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic          start,
    input  logic          loop,
    input  logic          halt,
    output logic [W-1:0]  A,
    output logic [W-1:0]  X,
    output logic          valid,
    output logic          first,
    output logic          last_n,
    output logic          done,
    output logic          busy
);

    localparam int unsigned A_DEPTH = M * N;
    localparam int unsigned X_DEPTH = N * P;
    localparam int unsigned AIW     = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned XIW     = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
    localparam int unsigned NW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MW      = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned PW      = (P > 1) ? $clog2(P) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [PW-1:0] P_LAST = PW'(P - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [NW-1:0]  n_q, n_d;
    logic [MW-1:0]  m_q, m_d;
    logic [PW-1:0]  p_q, p_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   x_q, x_d;
    logic           valid_q, valid_d;
    logic           first_q, first_d;
    logic           last_n_q, last_n_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [W-1:0]   a_mem [A_DEPTH];
    logic [W-1:0]   x_mem [X_DEPTH];
    logic [AIW-1:0] a_rd_idx;
    logic [XIW-1:0] x_rd_idx;
    logic           a_wr;
    logic           x_wr;

    // Loads only land while idle and inside the selected memory.
    assign a_wr = ld_en && (state_q == IDLE) && !ld_sel && (32'(ld_addr) < A_DEPTH);
    assign x_wr = ld_en && (state_q == IDLE) &&  ld_sel && (32'(ld_addr) < X_DEPTH);

    assign a_rd_idx = AIW'(m_q) * AIW'(N) + AIW'(n_q);
    assign x_rd_idx = XIW'(p_q) * XIW'(N) + XIW'(n_q);

    // Operand storage, never reset.
    always_ff @(posedge clk) begin
        if (a_wr) begin
            a_mem[AIW'(ld_addr)] <= ld_data;
        end
        if (x_wr) begin
            x_mem[XIW'(ld_addr)] <= ld_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        p_d      = p_q;
        a_d      = a_q;
        x_d      = x_q;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_n_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    n_d     = '0;
                    m_d     = '0;
                    p_d     = '0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                    n_d     = '0;
                    m_d     = '0;
                    p_d     = '0;
                end else begin
                    a_d      = a_mem[a_rd_idx];
                    x_d      = x_mem[x_rd_idx];
                    valid_d  = 1'b1;
                    first_d  = (n_q == '0) && (m_q == '0) && (p_q == '0);
                    last_n_d = (n_q == N_LAST);
                    // Nested wrap: n fastest, p slowest; end of pass ends the run unless looping.
                    if (n_q == N_LAST) begin
                        n_d = '0;
                        if (m_q == M_LAST) begin
                            m_d = '0;
                            if (p_q == P_LAST) begin
                                p_d = '0;
                                if (!loop) begin
                                    done_d  = 1'b1;
                                    state_d = IDLE;
                                end
                            end else begin
                                p_d = p_q + 1'b1;
                            end
                        end else begin
                            m_d = m_q + 1'b1;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            a_q      <= '0;
            x_q      <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_n_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            p_q      <= p_d;
            a_q      <= a_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_n_q <= last_n_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign A      = a_q;
    assign X      = x_q;
    assign valid  = valid_q;
    assign first  = first_q;
    assign last_n = last_n_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mxm_operand_feeder.sv
// Bench for mxm_operand_feeder: default-size instance plus a 2x3x2 instance,
// compared against an index-arithmetic reference of the stream order.
module tb_mxm_operand_feeder;

    localparam int unsigned W     = 8;
    localparam int unsigned M     = 10;
    localparam int unsigned N     = 8;
    localparam int unsigned P     = 6;
    localparam int unsigned AW    = $clog2((M * N > N * P) ? M * N : N * P);
    localparam int unsigned TOTAL = M * N * P;
    localparam int unsigned SM    = 2;
    localparam int unsigned SN    = 3;
    localparam int unsigned SP    = 2;
    localparam int unsigned SAW   = $clog2((SM * SN > SN * SP) ? SM * SN : SN * SP);
    localparam int unsigned STOT  = SM * SN * SP;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_en, ld_sel, start, loop, halt;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
    logic [W-1:0]  A, X;
    logic          valid, first, last_n, done, busy;

    logic           s_ld_en, s_ld_sel, s_start, s_loop, s_halt;
    logic [SAW-1:0] s_ld_addr;
    logic [W-1:0]   s_ld_data;
    logic [W-1:0]   s_A, s_X;
    logic           s_valid, s_first, s_last_n, s_done, s_busy;

    logic [W-1:0] a_ref [M*N];
    logic [W-1:0] x_ref [N*P];
    logic [W-1:0] sa_ref [SM*SN];
    logic [W-1:0] sx_ref [SN*SP];
    logic [W-1:0] cap_a [TOTAL];
    logic [W-1:0] cap_x [TOTAL];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned lastn_cnt;

    always #5 clk = ~clk;

    mxm_operand_feeder #(.W(W), .M(M), .N(N), .P(P)) u_dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .loop(loop), .halt(halt),
        .A(A), .X(X), .valid(valid), .first(first), .last_n(last_n),
        .done(done), .busy(busy)
    );

    mxm_operand_feeder #(.W(W), .M(SM), .N(SN), .P(SP)) u_small (
        .clk(clk), .rst(rst), .ld_en(s_ld_en), .ld_sel(s_ld_sel), .ld_addr(s_ld_addr),
        .ld_data(s_ld_data), .start(s_start), .loop(s_loop), .halt(s_halt),
        .A(s_A), .X(s_X), .valid(s_valid), .first(s_first), .last_n(s_last_n),
        .done(s_done), .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected element e of the stream, from the (p, m, n) nesting order.
    task automatic check_elem(input int unsigned e, input bit lp);
        int unsigned k, n, m, p;
        k = e % TOTAL;
        n = k % N;
        m = (k / N) % M;
        p = k / (N * M);
        chk($sformatf("e%0d_valid", e), 32'(valid), 32'd1);
        chk($sformatf("e%0d_A", e), 32'(A), 32'(a_ref[m*N+n]));
        chk($sformatf("e%0d_X", e), 32'(X), 32'(x_ref[p*N+n]));
        chk($sformatf("e%0d_first", e), 32'(first), 32'(k == 0));
        chk($sformatf("e%0d_last_n", e), 32'(last_n), 32'(n == N - 1));
        chk($sformatf("e%0d_done", e), 32'(done), 32'(!lp && (k == TOTAL - 1)));
        if (e < TOTAL) begin
            cap_a[e] = A;
            cap_x[e] = X;
        end
    endtask

    task automatic load(input bit sel, input int unsigned addr, input logic [W-1:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = AW'(addr);
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (!sel && addr < M * N) a_ref[addr] = d;
        if (sel && addr < N * P) x_ref[addr] = d;
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_valid_latency"}, 32'(valid), 32'd0);
    endtask

    task automatic run_pass(input string tag, input bit lp, input int unsigned count);
        loop = lp;
        lastn_cnt = 0;
        pulse_start(tag);
        for (int unsigned e = 0; e < count; e++) begin
            tick();
            check_elem(e, lp);
            lastn_cnt += 32'(last_n);
        end
    endtask

    task automatic do_halt(input string tag);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int unsigned r;
        rst = 1'b0;
        {ld_en, ld_sel, start, loop, halt} = '0;
        ld_addr = '0;
        ld_data = '0;
        {s_ld_en, s_ld_sel, s_start, s_loop, s_halt} = '0;
        s_ld_addr = '0;
        s_ld_data = '0;
        tick();
        tick();
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_X", 32'(X), 32'd0);
        check_idle("rst");
        chk("rst_first", 32'(first), 32'd0);
        chk("rst_last_n", 32'(last_n), 32'd0);
        rst = 1'b1;
        tick();

        // Directed contents: A[i] = i, X[i] = 0x80 + i.
        for (int unsigned i = 0; i < M * N; i++) load(1'b0, i, W'(i));
        for (int unsigned i = 0; i < N * P; i++) load(1'b1, i, W'(8'h80 + i));

        // Single pass.
        run_pass("pass", 1'b0, TOTAL);
        chk("pass_lastn_count", lastn_cnt, M * P);
        chk("e0_A_const", 32'(cap_a[0]), 32'h00);
        chk("e0_X_const", 32'(cap_x[0]), 32'h80);
        chk("e8_A_const", 32'(cap_a[8]), 32'h08);
        chk("e80_X_const", 32'(cap_x[80]), 32'h88);
        chk("e479_A_const", 32'(cap_a[479]), 32'h4F);
        chk("e479_X_const", 32'(cap_x[479]), 32'hAF);
        tick();
        check_idle("pass_end");
        tick();
        check_idle("pass_end2");

        // Loop mode: wraps with no bubble, never done.
        run_pass("loop", 1'b1, TOTAL + 10);
        loop = 1'b0;
        do_halt("loop_halt");

        // Halt after element 100.
        run_pass("halt", 1'b0, 101);
        do_halt("halt");
        tick();
        check_idle("halt_idle");
        run_pass("halt_restart", 1'b0, 3);
        do_halt("halt_restart");

        // Asynchronous reset mid-run.
        run_pass("arst", 1'b0, 5);
        rst = 1'b0;
        #1;
        chk("arst_A", 32'(A), 32'd0);
        chk("arst_X", 32'(X), 32'd0);
        check_idle("arst");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("arst_post%0d", i));
        end
        run_pass("arst_restart", 1'b0, 2);
        do_halt("arst_restart");

        // Out-of-range X write is dropped.
        load(1'b1, 48, 8'hEE);
        load(1'b0, 80, 8'hEE);
        run_pass("oor", 1'b0, TOTAL);
        tick();

        // Loads while busy are ignored.
        loop = 1'b0;
        pulse_start("busyld");
        for (int unsigned e = 0; e < 100; e++) begin
            ld_en   = 1'b1;
            ld_sel  = e[0];
            ld_addr = AW'(e % 48);
            ld_data = 8'hFF;
            tick();
            check_elem(e, 1'b0);
        end
        ld_en = 1'b0;
        do_halt("busyld");
        run_pass("busyld_verify", 1'b0, 100);
        do_halt("busyld_verify");

        // Load and start in the same cycle.
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = 8'h5A;
        start   = 1'b1;
        tick();
        {ld_en, start} = '0;
        a_ref[0] = 8'h5A;
        tick();
        check_elem(0, 1'b0);
        chk("ldstart_A", 32'(A), 32'h5A);
        do_halt("ldstart");

        // Random contents, full pass, then a random halt point.
        for (int unsigned i = 0; i < M * N; i++) load(1'b0, i, W'($urandom));
        for (int unsigned i = 0; i < N * P; i++) load(1'b1, i, W'($urandom));
        run_pass("rnd", 1'b0, TOTAL);
        chk("rnd_lastn_count", lastn_cnt, M * P);
        tick();
        check_idle("rnd_end");
        r = $urandom_range(5, 470);
        run_pass("rnd_halt", 1'b1, r);
        loop = 1'b0;
        do_halt("rnd_halt");

        // Small instance: 2x3x2, single pass.
        for (int unsigned i = 0; i < SM * SN; i++) begin
            s_ld_en   = 1'b1;
            s_ld_sel  = 1'b0;
            s_ld_addr = SAW'(i);
            s_ld_data = W'($urandom);
            sa_ref[i] = s_ld_data;
            tick();
        end
        for (int unsigned i = 0; i < SN * SP; i++) begin
            s_ld_en   = 1'b1;
            s_ld_sel  = 1'b1;
            s_ld_addr = SAW'(i);
            s_ld_data = W'($urandom);
            sx_ref[i] = s_ld_data;
            tick();
        end
        s_ld_en = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int unsigned e = 0; e < STOT; e++) begin
            int unsigned n, m, p;
            tick();
            n = e % SN;
            m = (e / SN) % SM;
            p = e / (SN * SM);
            chk($sformatf("s%0d_valid", e), 32'(s_valid), 32'd1);
            chk($sformatf("s%0d_A", e), 32'(s_A), 32'(sa_ref[m*SN+n]));
            chk($sformatf("s%0d_X", e), 32'(s_X), 32'(sx_ref[p*SN+n]));
            chk($sformatf("s%0d_first", e), 32'(s_first), 32'(e == 0));
            chk($sformatf("s%0d_last_n", e), 32'(s_last_n), 32'(n == SN - 1));
            chk($sformatf("s%0d_done", e), 32'(s_done), 32'(e == STOT - 1));
        end
        tick();
        chk("s_end_valid", 32'(s_valid), 32'd0);
        chk("s_end_busy", 32'(s_busy), 32'd0);
        chk("s_end_done", 32'(s_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mxm_operand_feeder.md
Name: mxm_operand_feeder

Overview:
- Upstream stage of the MxM_ReLu matrix-multiply/ReLU core.
- Holds operand matrix A (MxN, row-major) and the transpose of X (stored as PxN, so X column p is contiguous).
- Both are loaded through a simple write port.
- After start, streams one A element and one X element per clock in the order the core consumes them: n innermost, then m, then p outermost.

Parameters:
- W, 8, operand bit-width.
- M, 10, rows of A and rows of the result.
- N, 8, shared inner dimension.
- P, 6, columns of X and columns of the result.
- AW, $clog2(max(M*N, N*P)), load address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  load strobe; one operand word is written per cycle while high.
- ld_sel  in  1  load target: 0 = A memory, 1 = X memory.
- ld_addr  in  AW  A: m*N+n; X: p*N+n.
- ld_data  in  W  operand word.
- start  in  1  begin a streaming pass; sampled only in IDLE.
- loop  in  1  1 = wrap from p=P-1 back to p=0 and keep streaming; 0 = single pass.
- halt  in  1  abort streaming; sampled only in RUN.
- A  out  W  A element, registered.
- X  out  W  X element, registered.
- valid  out  1  A/X hold a stream element this cycle.
- first  out  1  with valid: element (p=0, m=0, n=0).
- last_n  out  1  with valid: element with n=N-1, i.e. the end of a dot product.
- done  out  1  one-cycle pulse with the final element of a single pass.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - state=IDLE.
  - A=0, X=0, valid=0, first=0, last_n=0, done=0, busy=0.
  - Counters n=m=p=0.
  - Operand memories are not cleared.
- Memories: A_mem has M*N entries, X_mem has N*P entries, each W bits, synchronous write.
  - Write happens at the edge when ld_en=1 and state=IDLE.
  - If ld_addr is out of range for the selected memory, the write is dropped.
  - ld_en while busy=1 is ignored; contents are unchanged.
- IDLE:
  - valid=0.
  - On an edge with start=1: counters cleared to 0, state goes to RUN, busy=1.
  - start and ld_en in the same cycle: the write is performed, and the streamed data reflects it.
- RUN, each edge:
  - A <= A_mem[m*N+n]; X <= X_mem[p*N+n]; valid <= 1.
  - first <= (p==0 && m==0 && n==0); last_n <= (n==N-1).
  - Counter advance: n+1. When n==N-1: n=0, m+1. When m==M-1: m=0, p+1. When p==P-1: p=0.
- Latency: start sampled at edge k gives first valid element after edge k+1. Output is then gap-free, one element per cycle.
- End of pass (element p=P-1, m=M-1, n=N-1 issued at edge j):
  - loop=0: done=1 and valid=1 after edge j. State returns to IDLE, so after edge j+1: valid=0, done=0, busy=0.
  - loop=1: no done. Next element is (0,0,0) with first=1, with no bubble.
- halt=1 at a RUN edge: no element is issued at that edge. valid=0, busy=0, state=IDLE, done stays 0, counters cleared. halt has priority over end-of-pass.
- halt in IDLE and start in RUN have no effect.
- Total elements per pass = M*N*P; default 480, with done on the 480th.
- Reset asserted mid-run: outputs drop immediately. After release, the block sits in IDLE until a new start.

Test Plan:
1. Reset behaviour: rst=0 asynchronously while valid=1 mid-run -> A=X=0, valid=busy=0 before the next edge; after release, no output until start.
2. Single pass, defaults, loop=0:
   - Stimulus: load A_mem[i]=i and X_mem[i]=0x80+i, then pulse start.
   - Element 0: A=0x00, X=0x80, first=1.
   - Element 8: A=0x08, X=0x80, last_n=0.
   - Element 80: A=0x00, X=0x88.
   - Element 479: A=0x4F, X=0xAF, done=1.
   - Element count exactly 480; last_n count 60.
3. Loop mode: same data with loop=1 -> element 480 is A=0x00, X=0x80, first=1, in the cycle directly after element 479; done never asserted.
4. Halt: halt=1 at the edge after element 100 is issued -> no element 101; valid, busy and done all 0 next cycle; a new start resumes at (0,0,0).
5. Load rules:
   - Write ld_sel=1, addr=48 (out of range for X) -> dropped; X_mem unchanged.
   - ld_en while busy -> stream values unchanged.
   - ld_en with start in the same cycle, addr=0 data 0x5A -> first element has A=0x5A.
6. Small-parameter run, M=2, N=3, P=2, loop=0 -> 12 elements in n/m/p order; last_n on elements 2, 5, 8, 11; done on element 11.
